regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-write-port register file for the pipelined CPU; successor to the single-write-port regfile.
- Two combinational read ports (rs, rt) and two synchronous write ports (A: ALU/MEM writeback, B: late/multicycle writeback).
- Per-register pending scoreboard: the decode stage marks a destination busy at issue, and writeback clears it.
- Busy flags and a stall output drive the hazard unit. A debug read port generalises the fixed reg28 tap.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- DEPTH, 1<<ADDR_W, number of registers; must be ≤ 2^ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never pending.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset, asynchronous, active-high.
- in_rs_addr  input  ADDR_W  read port rs address.
- in_rs_ena  input  1  read port rs enable.
- in_rt_addr  input  ADDR_W  read port rt address.
- in_rt_ena  input  1  read port rt enable.
- out_rs_data  output  DATA_W  rs read data.
- out_rt_data  output  DATA_W  rt read data.
- in_wa_ena  input  1  write port A enable.
- in_wa_addr  input  ADDR_W  write port A address.
- in_wa_data  input  DATA_W  write port A data.
- in_wb_ena  input  1  write port B enable.
- in_wb_addr  input  ADDR_W  write port B address.
- in_wb_data  input  DATA_W  write port B data.
- in_iss_ena  input  1  issue: mark destination pending.
- in_iss_addr  input  ADDR_W  issued destination register.
- out_rs_busy  output  1  rs operand not yet produced.
- out_rt_busy  output  1  rt operand not yet produced.
- out_stall  output  1  out_rs_busy OR out_rt_busy.
- in_dbg_addr  input  ADDR_W  debug read address.
- out_dbg_data  output  DATA_W  debug read data (array value only, no bypass).

Behaviour:
- Reset (in_rst high, async):
  - All DEPTH registers go to 0 and all pending bits go to 0.
  - While in_rst is high, out_rs_data, out_rt_data, out_dbg_data, busy flags and out_stall are all 0.
- Writes:
  - On the rising edge of in_clk, port A writes when in_wa_ena is high and the address is legal.
  - Port B writes the same way under in_wb_ena.
  - A and B to the same address in the same cycle: B wins.
- Illegal write addresses are ignored:
  - address ≥ DEPTH;
  - address 0 when ZERO_REG=1.
- Reads are combinational, zero latency.
  - Disabled port, address 0 with ZERO_REG=1, or address ≥ DEPTH: data = 0 and busy = 0.
  - Otherwise data = array value, subject to the bypass rules under Optional Feature.
- Scoreboard, one pending bit per register, updated on the rising edge:
  - Set when in_iss_ena is high and in_iss_addr is legal.
  - Cleared when a write to that address is enabled on port A or port B.
  - Issue and write to the same address in the same cycle: set wins (new producer supersedes).
  - Issue to an already-pending register: it stays pending (single outstanding producer tracked; no counting).
- Busy flags:
  - out_rs_busy = in_rs_ena AND pending[rs], after the bypass rules; out_rt_busy likewise.
  - Busy never asserts for an illegal address or for register 0 with ZERO_REG=1.
- Reset mid-operation: all pending bits and stored data are lost. Writes and issues in flight are dropped.
- No internal state machine beyond the storage and scoreboard. Every output is a function of current inputs and state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, legal write this cycle returns that write's data. If it matches both ports, port B data is returned.
  - The busy flag for that read is forced to 0 in the same cycle.
- Not defined:
  - Reads return the stored array value only, so the written value is visible from the next cycle.
  - Busy reflects the registered pending bit, so it clears one cycle after the write.

Test Plan:
- Reset, then read rs=5 and rt=31 with both enables high -> both data 0 and out_stall=0; assert in_rst asynchronously mid-cycle -> outputs 0 immediately.
- Same-address write priority: port A writes r3=0x11111111 and port B writes r3=0xDEADBEEF in the same cycle -> next cycle rs=3 reads 0xDEADBEEF; out_dbg_data for address 3 also shows 0xDEADBEEF.
- Register 0 with ZERO_REG=1: write r0=0xFFFFFFFF and issue r0 -> rs=0 reads 0 and out_rs_busy=0.
- Scoreboard:
  - Issue r7, next cycle read rs=7 -> out_rs_busy=1 and out_stall=1.
  - Port A writes r7=0x1234 -> with REGFILE_BYPASS_EN: same cycle data 0x1234 and busy 0; without it: busy clears and data reads 0x1234 the next cycle.
- Simultaneous issue r9 and port B write r9=0xAA -> r9 stores 0xAA and r9 remains pending (out_rt_busy=1 on rt=9) until the next write to r9.
- Disabled read: in_rs_ena=0 with r4 pending and r4=0x55 -> out_rs_data=0 and out_rs_busy=0; out_stall follows the rt port only.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-write-port register file with per-register pending scoreboard for the pipelined CPU.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_rs_addr,
  input  logic              in_rs_ena,
  input  logic [ADDR_W-1:0] in_rt_addr,
  input  logic              in_rt_ena,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  input  logic              in_wa_ena,
  input  logic [ADDR_W-1:0] in_wa_addr,
  input  logic [DATA_W-1:0] in_wa_data,
  input  logic              in_wb_ena,
  input  logic [ADDR_W-1:0] in_wb_addr,
  input  logic [DATA_W-1:0] in_wb_data,
  input  logic              in_iss_ena,
  input  logic [ADDR_W-1:0] in_iss_addr,
  output logic              out_rs_busy,
  output logic              out_rt_busy,
  output logic              out_stall,
  input  logic [ADDR_W-1:0] in_dbg_addr,
  output logic [DATA_W-1:0] out_dbg_data
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic legal(input logic [ADDR_W-1:0] a);
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  logic wa_ok, wb_ok, iss_ok;
  assign wa_ok  = in_wa_ena  && legal(in_wa_addr);
  assign wb_ok  = in_wb_ena  && legal(in_wb_addr);
  assign iss_ok = in_iss_ena && legal(in_iss_addr);

  // Port B is applied after port A so it wins on a shared address.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wa_ok) regs[in_wa_addr] <= in_wa_data;
      if (wb_ok) regs[in_wb_addr] <= in_wb_data;
    end
  end

  // Clears first, then the issue set, so a new producer supersedes a retiring one.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      pend <= '0;
    end else begin
      if (wa_ok)  pend[in_wa_addr]  <= 1'b0;
      if (wb_ok)  pend[in_wb_addr]  <= 1'b0;
      if (iss_ok) pend[in_iss_addr] <= 1'b1;
    end
  end

  always_comb begin
    out_rs_data = '0;
    out_rs_busy = 1'b0;
    if (!in_rst && in_rs_ena && legal(in_rs_addr)) begin
      out_rs_data = regs[in_rs_addr];
      out_rs_busy = pend[in_rs_addr];
`ifdef REGFILE_BYPASS_EN
      if (wa_ok && in_wa_addr == in_rs_addr) begin
        out_rs_data = in_wa_data;
        out_rs_busy = 1'b0;
      end
      if (wb_ok && in_wb_addr == in_rs_addr) begin
        out_rs_data = in_wb_data;
        out_rs_busy = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    out_rt_data = '0;
    out_rt_busy = 1'b0;
    if (!in_rst && in_rt_ena && legal(in_rt_addr)) begin
      out_rt_data = regs[in_rt_addr];
      out_rt_busy = pend[in_rt_addr];
`ifdef REGFILE_BYPASS_EN
      if (wa_ok && in_wa_addr == in_rt_addr) begin
        out_rt_data = in_wa_data;
        out_rt_busy = 1'b0;
      end
      if (wb_ok && in_wb_addr == in_rt_addr) begin
        out_rt_data = in_wb_data;
        out_rt_busy = 1'b0;
      end
`endif
    end
  end

  assign out_stall = out_rs_busy | out_rt_busy;

  always_comb begin
    out_dbg_data = '0;
    if (!in_rst && in_range(in_dbg_addr)) out_dbg_data = regs[in_dbg_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected outputs, a negedge monitor checks them.
// Expectations track REGFILE_BYPASS_EN when the bench is built with that macro.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wa_addr = '0, wb_addr = '0, iss_addr = '0, dbg_addr = '0;
  logic        rs_ena = 1'b0, rt_ena = 1'b0, wa_ena = 1'b0, wb_ena = 1'b0, iss_ena = 1'b0;
  logic [31:0] wa_data = '0, wb_data = '0;
  logic [31:0] rs_data, rt_data, dbg_data;
  logic        rs_busy, rt_busy, stall;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1)) dut (
    .in_clk(clk), .in_rst(rst),
    .in_rs_addr(rs_addr), .in_rs_ena(rs_ena),
    .in_rt_addr(rt_addr), .in_rt_ena(rt_ena),
    .out_rs_data(rs_data), .out_rt_data(rt_data),
    .in_wa_ena(wa_ena), .in_wa_addr(wa_addr), .in_wa_data(wa_data),
    .in_wb_ena(wb_ena), .in_wb_addr(wb_addr), .in_wb_data(wb_data),
    .in_iss_ena(iss_ena), .in_iss_addr(iss_addr),
    .out_rs_busy(rs_busy), .out_rt_busy(rt_busy), .out_stall(stall),
    .in_dbg_addr(dbg_addr), .out_dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] dbg_d;
    logic        rs_b;
    logic        rt_b;
    logic        st;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    vectors = 0;
  int    miscompares = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{rs_d: rs_data, rt_d: rt_data, dbg_d: dbg_data, rs_b: rs_busy, rt_b: rt_busy, st: stall};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got rs=%h rt=%h dbg=%h rs_busy=%b rt_busy=%b stall=%b, want rs=%h rt=%h dbg=%h rs_busy=%b rt_busy=%b stall=%b",
                 n, a.rs_d, a.rt_d, a.dbg_d, a.rs_b, a.rt_b, a.st,
                 e.rs_d, e.rt_d, e.dbg_d, e.rs_b, e.rt_b, e.st);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wa_ena = 1'b0; wb_ena = 1'b0; iss_ena = 1'b0;
  endtask

  task automatic expect_out(input string n, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic rsb, input logic rtb, input logic [31:0] dbgd);
    exp_q.push_back('{rs_d: rsd, rt_d: rtd, dbg_d: dbgd, rs_b: rsb, rt_b: rtb, st: rsb | rtb});
    name_q.push_back(n);
  endtask

  task automatic rd(input logic re, input logic [4:0] ra, input logic te, input logic [4:0] ta,
                    input logic [4:0] da);
    rs_ena = re; rs_addr = ra; rt_ena = te; rt_addr = ta; dbg_addr = da;
  endtask

  initial begin
    // Reset held: outputs forced to zero
    step();
    rd(1, 5, 1, 31, 0);
    expect_out("rst_hold", 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    expect_out("post_reset", 0, 0, 0, 0, 0);

    // Same-address A/B write, B wins
    step();
    wa_ena = 1; wa_addr = 3; wa_data = 32'h1111_1111;
    wb_ena = 1; wb_addr = 3; wb_data = 32'hDEAD_BEEF;
    rd(1, 3, 0, 0, 3);
    expect_out("wr_same_cycle", BYP ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0, 0);
    step();
    expect_out("prio_b_wins", 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF);

    // Register 0 ignores writes and issues
    step();
    wa_ena = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF;
    iss_ena = 1; iss_addr = 0;
    rd(1, 0, 0, 0, 0);
    expect_out("zero_wr_cycle", 0, 0, 0, 0, 0);
    step();
    expect_out("zero_reg", 0, 0, 0, 0, 0);

    // Scoreboard on r7
    step();
    iss_ena = 1; iss_addr = 7;
    rd(1, 7, 0, 0, 7);
    expect_out("iss_r7_same", 0, 0, 0, 0, 0);
    step();
    expect_out("r7_busy", 0, 0, 1, 0, 0);
    step();
    wa_ena = 1; wa_addr = 7; wa_data = 32'h0000_1234;
    expect_out("r7_write", BYP ? 32'h1234 : 32'h0, 0, !BYP, 0, 0);
    step();
    expect_out("r7_after", 32'h1234, 0, 0, 0, 32'h1234);

    // Issue and port-B write to r9 together: data stored, stays pending
    step();
    iss_ena = 1; iss_addr = 9;
    wb_ena = 1; wb_addr = 9; wb_data = 32'h0000_00AA;
    rd(0, 0, 1, 9, 9);
    expect_out("r9_iss_wr", 0, BYP ? 32'hAA : 32'h0, 0, 0, 0);
    step();
    expect_out("r9_pending", 0, 32'hAA, 0, 1, 32'hAA);
    step();
    expect_out("r9_still", 0, 32'hAA, 0, 1, 32'hAA);
    step();
    wa_ena = 1; wa_addr = 9; wa_data = 32'h0000_00BB;
    expect_out("r9_rewrite", 0, BYP ? 32'hBB : 32'hAA, 0, !BYP, 32'hAA);
    step();
    expect_out("r9_cleared", 0, 32'hBB, 0, 0, 32'hBB);

    // Independent writes on both ports
    step();
    wa_ena = 1; wa_addr = 10; wa_data = 32'hA0A0_A0A0;
    wb_ena = 1; wb_addr = 11; wb_data = 32'hB1B1_B1B1;
    rd(1, 10, 1, 11, 10);
    expect_out("dual_wr_cycle", BYP ? 32'hA0A0_A0A0 : 32'h0, BYP ? 32'hB1B1_B1B1 : 32'h0, 0, 0, 0);
    step();
    expect_out("dual_wr_after", 32'hA0A0_A0A0, 32'hB1B1_B1B1, 0, 0, 32'hA0A0_A0A0);

    // Disabled rs port with r4 pending
    step();
    iss_ena = 1; iss_addr = 4;
    wa_ena = 1; wa_addr = 4; wa_data = 32'h0000_0055;
    rd(0, 4, 0, 4, 4);
    expect_out("r4_setup", 0, 0, 0, 0, 0);
    step();
    rd(0, 4, 1, 7, 4);
    expect_out("dis_rs", 0, 32'h1234, 0, 0, 32'h55);
    step();
    rd(0, 4, 1, 4, 4);
    expect_out("dis_rs_rt_busy", 0, 32'h55, 0, 1, 32'h55);

    // Asynchronous reset mid-cycle
    step();
    rd(1, 3, 1, 4, 3);
    expect_out("async_rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    expect_out("after_rst", 0, 0, 0, 0, 0);

    begin
      int budget = 8;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1;
      if (exp_q.size() > 0) begin
        $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        miscompares += exp_q.size();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
